drum_seq_ctrl: RTL and testbench

DRUM_SEQ_CTRL -- requirements
Module: drum_seq_ctrl

---
 rtl/drum_pkg.sv | 15 +
 rtl/lod.sv | 19 +
 rtl/drum_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_drum_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared constants and FSM state type for the DRUM approximate multiplier sequencer.
package drum_pkg;

    localparam int DRUM_INPUT_SIZE = 16;
    localparam int DRUM_K          = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DET_A = 3'd1,
        ST_DET_B = 3'd2,
        ST_MULT  = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

endpackage

// File: rtl/lod.sv
// Leading-one detector: one-hot marker of the most significant set bit, all zeros for zero input.
module lod #(
    parameter int W = 16
) (
    input  logic [W-1:0] d,
    output logic [W-1:0] one_hot
);

    always_comb begin
        one_hot = '0;
        for (int i = 0; i < W; i++) begin
            if (d[i]) begin
                one_hot    = '0;
                one_hot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/drum_seq_ctrl.sv
// Sequenced DRUM approximate multiplier: one shared LOD walks both operands, then one
// truncated-mantissa multiply and shift produce the product.
//
//   state  | meaning
//   IDLE   | ready for an operand pair
//   DET_A  | LOD on a_q, capture ta/sa/za
//   DET_B  | LOD on b_q, capture tb/sb/zb
//   MULT   | register (ta*tb) << (sa+sb)
//   OUT    | hold product until out_ready
module drum_seq_ctrl
    import drum_pkg::*;
#(
    parameter int INPUT_SIZE = DRUM_INPUT_SIZE,
    parameter int K          = DRUM_K
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INPUT_SIZE-1:0]   a_i,
    input  logic [INPUT_SIZE-1:0]   b_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*INPUT_SIZE-1:0] product_o,
    output logic                    busy_o
);

    localparam int IDX_W = $clog2(INPUT_SIZE);
    localparam int S_W   = IDX_W + 1;
    localparam int SH_W  = S_W + 1;
    localparam int PW    = 2 * INPUT_SIZE;
    localparam logic [S_W-1:0] K_S = S_W'(K);

    state_t                  state;
    logic [INPUT_SIZE-1:0]   a_q, b_q;
    logic [K-1:0]            ta, tb;
    logic [S_W-1:0]          sa, sb;
    logic                    za, zb;

    logic [INPUT_SIZE-1:0]   lod_in, lod_oh;
    logic [IDX_W-1:0]        lod_idx;
    logic                    lod_zero;
    logic [S_W-1:0]          p_ext, cur_s;
    logic [K-1:0]            cur_t;
    logic [SH_W-1:0]         shamt;
    logic [PW-1:0]           prod_full;

    always_comb begin
        lod_in = '0;
        if (state == ST_DET_A)
            lod_in = a_q;
        else if (state == ST_DET_B)
            lod_in = b_q;
    end

    lod #(.W(INPUT_SIZE)) u_lod (
        .d       (lod_in),
        .one_hot (lod_oh)
    );

    always_comb begin
        lod_idx = '0;
        for (int i = 0; i < INPUT_SIZE; i++) begin
            if (lod_oh[i])
                lod_idx = lod_idx | IDX_W'(i);
        end
    end

    assign lod_zero = ~|lod_oh;

    // Below K bits the operand is already exact; above it keep the top K bits with a forced LSB.
    always_comb begin
        p_ext = {1'b0, lod_idx};
        cur_s = '0;
        cur_t = K'(lod_in);
        if (p_ext >= K_S) begin
            cur_s = p_ext - K_S + S_W'(1);
            cur_t = K'(lod_in >> cur_s) | K'(1);
        end
    end

    assign shamt     = SH_W'(sa) + SH_W'(sb);
    assign prod_full = (PW'(ta) * PW'(tb)) << shamt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy_o    <= 1'b0;
            product_o <= '0;
            a_q       <= '0;
            b_q       <= '0;
            ta        <= '0;
            tb        <= '0;
            sa        <= '0;
            sb        <= '0;
            za        <= 1'b0;
            zb        <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a_i;
                        b_q      <= b_i;
                        in_ready <= 1'b0;
                        busy_o   <= 1'b1;
                        state    <= ST_DET_A;
                    end
                end
                ST_DET_A: begin
                    ta    <= cur_t;
                    sa    <= cur_s;
                    za    <= lod_zero;
                    state <= ST_DET_B;
                end
                ST_DET_B: begin
                    tb    <= cur_t;
                    sb    <= cur_s;
                    zb    <= lod_zero;
                    state <= ST_MULT;
                end
                ST_MULT: begin
                    product_o <= (za | zb) ? '0 : prod_full;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy_o    <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drum_seq_ctrl.sv
// Self-checking bench for drum_seq_ctrl: directed corner cases plus a randomized run
// against an arithmetic DRUM reference model.
module tb_drum_seq_ctrl;

    localparam int N  = 16;
    localparam int KK = 6;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N-1:0]   a_i = '0;
    logic [N-1:0]   b_i = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*N-1:0] product_o;
    logic           busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    drum_seq_ctrl #(.INPUT_SIZE(N), .K(KK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_i       (a_i),
        .b_i       (b_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product_o (product_o),
        .busy_o    (busy_o)
    );

    task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: position of the leading one, keep K bits below it with a forced LSB.
    function automatic int msb_pos(input int unsigned x);
        int p = 0;
        while ((x >> (p + 1)) != 0) p++;
        return p;
    endfunction

    function automatic int drum_shift(input int unsigned x);
        int p = msb_pos(x);
        return (p < KK) ? 0 : p - KK + 1;
    endfunction

    function automatic longint unsigned drum_mant(input int unsigned x);
        int s = drum_shift(x);
        if (s == 0) return longint'(x);
        return longint'((x >> s) | 1);
    endfunction

    function automatic longint unsigned drum_ref(input int unsigned a, input int unsigned b);
        if (a == 0 || b == 0) return 0;
        return (drum_mant(a) * drum_mant(b)) << (drum_shift(a) + drum_shift(b));
    endfunction

    function automatic logic [N-1:0] rand_operand();
        case ($urandom_range(3))
            0: return N'($urandom_range(63));
            1: return N'(1 << $urandom_range(N - 1)) | N'($urandom_range(3));
            2: return ($urandom_range(15) == 0) ? '0 : N'($urandom);
            default: return N'($urandom);
        endcase
    endfunction

    // One full transaction; noise on in_valid/a_i/b_i while busy must be ignored.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input longint unsigned exp, input int ready_pct);
        int cnt;
        int w;
        bit done;
        in_valid = 1'b1;
        a_i = a;
        b_i = b;
        tick();
        cnt = 0;
        while (!out_valid && cnt < 12) begin
            in_valid  = 1'($urandom_range(1));
            a_i       = N'($urandom);
            b_i       = N'($urandom);
            out_ready = 1'($urandom_range(1));
            tick();
            cnt++;
        end
        check("latency", cnt, 3);
        check("busy_in_out", busy_o, 1);
        check("in_ready_in_out", in_ready, 0);
        check("product", product_o, exp);
        done = 1'b0;
        w = 0;
        while (!done && w < 40) begin
            out_ready = ($urandom_range(99) < ready_pct);
            in_valid  = 1'($urandom_range(1));
            a_i       = N'($urandom);
            b_i       = N'($urandom);
            tick();
            w++;
            if (out_ready)
                done = 1'b1;
            else
                check("hold_product", product_o, exp);
        end
        check("handshake_done", done, 1);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("idle_ready", in_ready, 1);
        check("idle_valid", out_valid, 0);
        check("idle_busy", busy_o, 0);
    endtask

    initial begin
        bit stale;
        logic [N-1:0] ra, rb;

        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy_o, 0);
        check("rst_product", product_o, 0);
        rst_n = 1'b1;
        tick();

        run_op(16'd3, 16'd5, 64'd15, 100);
        run_op(16'd100, 16'd1, 64'd102, 100);
        run_op(16'hFFFF, 16'hFFFF, 64'hF810_0000, 100);
        run_op(16'd0, 16'h1234, 64'd0, 100);
        run_op(16'h1234, 16'd0, 64'd0, 100);
        run_op(16'd63, 16'd32, 64'd2016, 100);

        // Backpressure: hold out_ready low for 3 cycles while offering a new pair.
        in_valid = 1'b1;
        a_i = 16'h0F0F;
        b_i = 16'h00FF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a_i = 16'd1;
            b_i = 16'd1;
            tick();
            check("bp_hold", product_o, drum_ref(32'h0F0F, 32'h00FF));
            check("bp_in_ready", in_ready, 0);
            check("bp_still_valid", out_valid, 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_idle", in_ready, 1);
        check("bp_release_valid", out_valid, 0);
        stale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid || busy_o) stale = 1'b1;
        end
        check("bp_no_second_op", stale, 0);

        // Reset in MULT: the in-flight operation must vanish.
        in_valid = 1'b1;
        a_i = 16'h1234;
        b_i = 16'h5678;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_busy", busy_o, 1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_product", product_o, 0);
        #2;
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid || busy_o || !in_ready) stale = 1'b1;
        end
        check("post_rst_quiet", stale, 0);
        run_op(16'd7, 16'd9, 64'd63, 100);

        for (int n = 0; n < 10000; n++) begin
            ra = rand_operand();
            rb = rand_operand();
            run_op(ra, rb, drum_ref(32'(ra), 32'(rb)), 75);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
